// File: rtl/tetris_pkg.sv
// Shared definitions for the piece commit controller.
//   state_t : FSM state encoding (IDLE / CHECK / WAIT / LOCK)
//   move_t  : move-select encoding; the value is also the pending-flag index
//   X_W / Y_W / ROT_W : coordinate widths
//   SPAWN_X_DEF / SPAWN_Y_DEF : default spawn position
package tetris_pkg;

  localparam int X_W   = 4;
  localparam int Y_W   = 4;
  localparam int ROT_W = 2;
  localparam int N_MV  = 5;

  localparam logic [X_W-1:0] SPAWN_X_DEF = 4'd3;
  localparam logic [Y_W-1:0] SPAWN_Y_DEF = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  // Order matches service priority: lower value wins.
  typedef enum logic [2:0] {
    MV_LEFT  = 3'd0,
    MV_RIGHT = 3'd1,
    MV_ROT   = 3'd2,
    MV_DOWN  = 3'd3,
    MV_GRAV  = 3'd4
  } move_t;

endpackage

// File: rtl/move_pending_reg.sv
// Pending-move flags with fixed-priority pick.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_set      : one pulse per move, bit index = move_t value
//   i_take     : clear the flag of the currently picked move
//   i_flush    : clear every flag (pulses in the same cycle survive)
//   o_any      : at least one flag is pending
//   o_move     : highest-priority pending move (L > R > ROT > DN > GRAV)
module move_pending_reg
  import tetris_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_MV-1:0] i_set,
  input  logic            i_take,
  input  logic            i_flush,
  output logic            o_any,
  output move_t           o_move
);

  logic [N_MV-1:0] r_flags;
  logic [N_MV-1:0] w_clr;
  logic [N_MV-1:0] w_flags_next;

  always_comb begin
    casez (r_flags)
      5'b????1: o_move = MV_LEFT;
      5'b???10: o_move = MV_RIGHT;
      5'b??100: o_move = MV_ROT;
      5'b?1000: o_move = MV_DOWN;
      default:  o_move = MV_GRAV;
    endcase
  end

  assign o_any = |r_flags;

  always_comb begin
    w_clr = '0;
    if (i_flush)
      w_clr = '1;
    else if (i_take)
      w_clr = N_MV'(1) << o_move;
  end

  // Set after clear: a pulse landing on the cycle its flag is serviced or
  // flushed is kept pending rather than lost.
  assign w_flags_next = (r_flags & ~w_clr) | i_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_flags <= '0;
    else
      r_flags <= w_flags_next;
  end

endmodule

// File: rtl/piece_commit_ctrl.sv
// Serialises piece moves through an external collision checker.
//   clk, rst_n              : clock, asynchronous active-low reset
//   gravity_tick, btn_*_en  : one-cycle move requests
//   test_pos_x/y, test_rot  : proposal from the test-position calculator
//   sel_*                   : move presented to the calculator (0 = gravity)
//   chk_req                 : one-cycle collision-check request
//   chk_done, chk_collide   : check result
//   cur_pos_x/y, cur_rot    : committed piece state
//   piece_lock              : one-cycle pulse when the piece settles
//   busy                    : FSM not idle
module piece_commit_ctrl
  import tetris_pkg::*;
#(
  parameter logic [X_W-1:0] SPAWN_X = SPAWN_X_DEF,
  parameter logic [Y_W-1:0] SPAWN_Y = SPAWN_Y_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gravity_tick,
  input  logic             btn_left_en,
  input  logic             btn_right_en,
  input  logic             btn_rotate_en,
  input  logic             btn_down_en,
  input  logic [X_W-1:0]   test_pos_x,
  input  logic [Y_W-1:0]   test_pos_y,
  input  logic [ROT_W-1:0] test_rot,
  output logic             sel_left,
  output logic             sel_right,
  output logic             sel_rotate,
  output logic             sel_down,
  output logic             chk_req,
  input  logic             chk_done,
  input  logic             chk_collide,
  output logic [X_W-1:0]   cur_pos_x,
  output logic [Y_W-1:0]   cur_pos_y,
  output logic [ROT_W-1:0] cur_rot,
  output logic             piece_lock,
  output logic             busy
);

  state_t            r_state;
  state_t            w_state_next;
  move_t             r_move;
  logic [X_W-1:0]    r_cap_x;
  logic [Y_W-1:0]    r_cap_y;
  logic [ROT_W-1:0]  r_cap_rot;
  logic [X_W-1:0]    r_cur_x;
  logic [Y_W-1:0]    r_cur_y;
  logic [ROT_W-1:0]  r_cur_rot;

  logic              w_any;
  move_t             w_pick;
  logic              w_take;
  logic              w_flush;
  logic              w_can_lock;
  logic [N_MV-1:0]   w_set;

  assign w_set   = {gravity_tick, btn_down_en, btn_rotate_en, btn_right_en, btn_left_en};
  assign w_take  = (r_state == ST_IDLE) && w_any;
  assign w_flush = (r_state == ST_LOCK);

  // Only downward motion can settle the piece; sideways/rotate collisions
  // are simply rejected.
  assign w_can_lock = (r_move == MV_DOWN) || (r_move == MV_GRAV);

  move_pending_reg u_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_set   (w_set),
    .i_take  (w_take),
    .i_flush (w_flush),
    .o_any   (w_any),
    .o_move  (w_pick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = ST_WAIT;
      ST_WAIT:  if (chk_done)
                  w_state_next = (chk_collide && w_can_lock) ? ST_LOCK : ST_IDLE;
      ST_LOCK:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    sel_left   = 1'b0;
    sel_right  = 1'b0;
    sel_rotate = 1'b0;
    sel_down   = 1'b0;
    chk_req    = 1'b0;
    piece_lock = 1'b0;
    busy       = (r_state != ST_IDLE);
    if (r_state == ST_CHECK || r_state == ST_WAIT) begin
      sel_left   = (r_move == MV_LEFT);
      sel_right  = (r_move == MV_RIGHT);
      sel_rotate = (r_move == MV_ROT);
      sel_down   = (r_move == MV_DOWN);
    end
    if (r_state == ST_CHECK) chk_req    = 1'b1;
    if (r_state == ST_LOCK)  piece_lock = 1'b1;
  end

  // Move latch, proposal capture and committed piece state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_move    <= MV_GRAV;
      r_cap_x   <= '0;
      r_cap_y   <= '0;
      r_cap_rot <= '0;
      r_cur_x   <= SPAWN_X;
      r_cur_y   <= SPAWN_Y;
      r_cur_rot <= '0;
    end else begin
      if (w_take)
        r_move <= w_pick;
      if (r_state == ST_CHECK) begin
        r_cap_x   <= test_pos_x;
        r_cap_y   <= test_pos_y;
        r_cap_rot <= test_rot;
      end
      if (r_state == ST_WAIT && chk_done && !chk_collide) begin
        r_cur_x   <= r_cap_x;
        r_cur_y   <= r_cap_y;
        r_cur_rot <= r_cap_rot;
      end else if (r_state == ST_LOCK) begin
        r_cur_x   <= SPAWN_X;
        r_cur_y   <= SPAWN_Y;
        r_cur_rot <= '0;
      end
    end
  end

  assign cur_pos_x = r_cur_x;
  assign cur_pos_y = r_cur_y;
  assign cur_rot   = r_cur_rot;

endmodule

// File: tb/tb_piece_commit_ctrl.sv
// Directed bench for piece_commit_ctrl; expected sel_* vectors are queued
// as each request is driven and popped when chk_req appears.
module tb_piece_commit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gravity_tick, btn_left_en, btn_right_en, btn_rotate_en, btn_down_en;
  logic [3:0] test_pos_x, test_pos_y;
  logic [1:0] test_rot;
  logic       sel_left, sel_right, sel_rotate, sel_down;
  logic       chk_req, chk_done, chk_collide;
  logic [3:0] cur_pos_x, cur_pos_y;
  logic [1:0] cur_rot;
  logic       piece_lock, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_req   = 0;
  int n_lock  = 0;
  logic [3:0] exp_sel_q[$];   // {left,right,rotate,down}

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_req)    n_req++;
    if (piece_lock) n_lock++;
  end

  piece_commit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .gravity_tick(gravity_tick),
    .btn_left_en(btn_left_en), .btn_right_en(btn_right_en),
    .btn_rotate_en(btn_rotate_en), .btn_down_en(btn_down_en),
    .test_pos_x(test_pos_x), .test_pos_y(test_pos_y), .test_rot(test_rot),
    .sel_left(sel_left), .sel_right(sel_right), .sel_rotate(sel_rotate),
    .sel_down(sel_down), .chk_req(chk_req), .chk_done(chk_done),
    .chk_collide(chk_collide), .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y),
    .cur_rot(cur_rot), .piece_lock(piece_lock), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      $display("[TB] %-14s obs=%0h exp=%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cur_vec();
    return {22'd0, cur_pos_x, cur_pos_y, cur_rot};
  endfunction

  function automatic logic [31:0] pack_cur(input int x, input int y, input int r);
    logic [3:0] xx, yy;
    logic [1:0] rr;
    xx = 4'(x); yy = 4'(y); rr = 2'(r);
    return {22'd0, xx, yy, rr};
  endfunction

  // bits: {grav, down, rot, right, left}
  task automatic pulse(input logic [4:0] s);
    {gravity_tick, btn_down_en, btn_rotate_en, btn_right_en, btn_left_en} = s;
    tick();
    {gravity_tick, btn_down_en, btn_rotate_en, btn_right_en, btn_left_en} = '0;
  endtask

  task automatic wait_req(input string tag);
    logic [3:0] e;
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (chk_req) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (exp_sel_q.size() == 0) begin
      check({tag, "_unexp_req"}, 32'd1, 32'd0);
    end else begin
      e = exp_sel_q.pop_front();
      check({tag, "_sel"}, {28'd0, sel_left, sel_right, sel_rotate, sel_down}, {28'd0, e});
      tick();   // now in WAIT
      check({tag, "_sel_hold"}, {28'd0, sel_left, sel_right, sel_rotate, sel_down}, {28'd0, e});
    end
  endtask

  // Return the check result one cycle after chk_req; optionally pulse left meanwhile.
  task automatic serve(input string tag, input logic collide, input logic extra_left);
    wait_req(tag);
    chk_done = 1'b1;
    chk_collide = collide;
    btn_left_en = extra_left;
    tick();
    chk_done = 1'b0;
    chk_collide = 1'b0;
    btn_left_en = 1'b0;
  endtask

  task automatic set_test(input int x, input int y, input int r);
    test_pos_x = 4'(x); test_pos_y = 4'(y); test_rot = 2'(r);
  endtask

  initial begin
    int lk, rq;
    rst_n = 1'b0;
    {gravity_tick, btn_down_en, btn_rotate_en, btn_right_en, btn_left_en} = '0;
    chk_done = 1'b0; chk_collide = 1'b0;
    set_test(0, 0, 0);
    tick(); tick();

    // Reset state
    check("rst_cur", cur_vec(), pack_cur(3, 0, 0));
    check("rst_outs", {27'd0, busy, chk_req, piece_lock, sel_left | sel_right, sel_rotate | sel_down},
          32'd0);
    rst_n = 1'b1;
    tick();

    // Left commit
    lk = n_lock;
    set_test(4, 0, 0);
    exp_sel_q.push_back(4'b1000);
    pulse(5'b00001);
    serve("left", 1'b0, 1'b0);
    check("left_cur", cur_vec(), pack_cur(4, 0, 0));
    check("left_sel_idle", {28'd0, sel_left, sel_right, sel_rotate, sel_down}, 32'd0);
    check("left_busy", {31'd0, busy}, 32'd0);
    check("left_nolock", n_lock, lk);

    // Move to (5,7,3) via a down commit, then a colliding rotate
    set_test(5, 7, 3);
    exp_sel_q.push_back(4'b0001);
    pulse(5'b01000);
    serve("down_mv", 1'b0, 1'b0);
    check("down_cur", cur_vec(), pack_cur(5, 7, 3));
    lk = n_lock;
    set_test(6, 7, 0);
    exp_sel_q.push_back(4'b0010);
    pulse(5'b00100);
    serve("rot_col", 1'b1, 1'b0);
    check("rot_cur", cur_vec(), pack_cur(5, 7, 3));
    check("rot_idle", {31'd0, busy}, 32'd0);
    tick();
    check("rot_nolock", n_lock, lk);

    // Move to (2,14,1), then gravity collides and locks
    set_test(2, 14, 1);
    exp_sel_q.push_back(4'b0001);
    pulse(5'b01000);
    serve("down_mv2", 1'b0, 1'b0);
    check("down2_cur", cur_vec(), pack_cur(2, 14, 1));
    set_test(2, 15, 1);
    exp_sel_q.push_back(4'b0000);
    pulse(5'b10000);
    serve("grav_col", 1'b1, 1'b0);
    check("grav_lock", {31'd0, piece_lock}, 32'd1);
    check("grav_cur_hold", cur_vec(), pack_cur(2, 14, 1));
    tick();
    check("grav_lock_1cy", {31'd0, piece_lock}, 32'd0);
    check("grav_spawn", cur_vec(), pack_cur(3, 0, 0));

    // Right and gravity together: R first, then GRAV
    rq = n_req;
    set_test(4, 0, 0);
    exp_sel_q.push_back(4'b0100);
    exp_sel_q.push_back(4'b0000);
    pulse(5'b10010);
    serve("sim_right", 1'b0, 1'b0);
    check("sim_r_cur", cur_vec(), pack_cur(4, 0, 0));
    set_test(4, 1, 0);
    serve("sim_grav", 1'b0, 1'b0);
    check("sim_g_cur", cur_vec(), pack_cur(4, 1, 0));
    repeat (5) tick();
    check("sim_nreq", n_req - rq, 2);

    // Left pulsed during a colliding down check is flushed by the lock
    set_test(4, 2, 0);
    exp_sel_q.push_back(4'b0001);
    pulse(5'b01000);
    serve("flush_dn", 1'b1, 1'b1);
    check("flush_lock", {31'd0, piece_lock}, 32'd1);
    rq = n_req;
    repeat (10) tick();
    check("flush_noreq", n_req, rq);
    check("flush_spawn", cur_vec(), pack_cur(3, 0, 0));
    check("flush_busy", {31'd0, busy}, 32'd0);

    // Reset mid-WAIT abandons the move; late chk_done ignored
    set_test(9, 9, 2);
    exp_sel_q.push_back(4'b1000);
    pulse(5'b00001);
    wait_req("rst_wait");
    rst_n = 1'b0;
    #2;
    check("rstw_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rq = n_req;
    chk_done = 1'b1;
    tick(); tick();
    chk_done = 1'b0;
    tick();
    check("rstw_cur", cur_vec(), pack_cur(3, 0, 0));
    check("rstw_idle", {31'd0, busy}, 32'd0);
    check("rstw_noreq", n_req, rq);

    check("sb_empty", exp_sel_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piece_commit_ctrl.md
PIECE_COMMIT_CTRL -- requirements
Module: piece_commit_ctrl

Interface
REQ-001 The block SHALL have parameter SPAWN_X, default 4'd3, the x coordinate loaded on reset and after lock.
REQ-002 The block SHALL have parameter SPAWN_Y, default 4'd0, the y coordinate loaded on reset and after lock.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port gravity_tick, input, 1 bit: one-cycle gravity pulse.
REQ-006 Ports btn_left_en, btn_right_en, btn_rotate_en and btn_down_en, inputs, 1 bit each: one-cycle button pulses.
REQ-007 Ports test_pos_x and test_pos_y, inputs, 4 bits each, and port test_rot, input, 2 bits: the proposal from the test-position calculator.
REQ-008 Ports sel_left, sel_right, sel_rotate and sel_down, outputs, 1 bit each: the move presented to the calculator; all 0 means a gravity step.
REQ-009 Port chk_req, output, 1 bit: one-cycle collision-check request.
REQ-010 Port chk_done, input, 1 bit, and port chk_collide, input, 1 bit: the check result; chk_collide is valid only while chk_done=1.
REQ-011 Ports cur_pos_x and cur_pos_y, outputs, 4 bits each, and port cur_rot, output, 2 bits: the committed piece state.
REQ-012 Port piece_lock, output, 1 bit: one-cycle pulse when the piece settles.
REQ-013 Port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-014 The block SHALL keep five pending flags (L, R, ROT, DN, GRAV), each set by its input pulse in any state.
REQ-015 A pulse arriving while its flag is already set SHALL merge into that flag, so at most one service occurs per flag.
REQ-016 The FSM SHALL have exactly four states: IDLE, CHECK, WAIT and LOCK.
REQ-017 In IDLE with any flag set, the block SHALL choose one move by priority L > R > ROT > DN > GRAV, clear only that flag, and go to CHECK on the next edge.
REQ-018 A pulse arriving in the same cycle as the IDLE selection SHALL still be captured as pending.
REQ-019 The sel_* outputs SHALL be one-hot for the chosen move, or all 0 for GRAV, and SHALL be held stable from CHECK through WAIT.
REQ-020 The sel_* outputs SHALL be all 0 in IDLE and in LOCK.
REQ-021 In CHECK the block SHALL assert chk_req for exactly one cycle, capture test_pos_x, test_pos_y and test_rot into internal registers, and go to WAIT.
REQ-022 In WAIT with chk_done=0, the block SHALL hold all state indefinitely; there is no timeout.
REQ-023 In WAIT with chk_done=1 and chk_collide=0, the block SHALL load the captured values into cur_* and return to IDLE.
REQ-024 In WAIT with chk_done=1 and chk_collide=1 for L, R or ROT, the block SHALL leave cur_* unchanged and return to IDLE.
REQ-025 In WAIT with chk_done=1 and chk_collide=1 for DN or GRAV, the block SHALL go to LOCK.
REQ-026 The LOCK state SHALL last one cycle: piece_lock=1; cur_pos_x←SPAWN_X, cur_pos_y←SPAWN_Y, cur_rot←0; all pending flags cleared; then IDLE.
REQ-027 Pulses arriving during the LOCK cycle itself SHALL be captured and not cleared.
REQ-028 A chk_done arriving in any state other than WAIT SHALL be ignored.
REQ-029 Commit latency SHALL be 3 cycles from IDLE-selection to cur_* update when chk_done returns in the cycle after chk_req.
REQ-030 All coordinate arithmetic SHALL be performed by the calculator; this block only stores values, 4-bit/2-bit unsigned, with no wrap handling.

Reset
REQ-031 While rst_n=0 the outputs SHALL be: state IDLE, all flags 0, cur_pos_x=SPAWN_X, cur_pos_y=SPAWN_Y, cur_rot=0, and chk_req, piece_lock, busy and sel_* all 0.
REQ-032 A reset asserted mid-CHECK or mid-WAIT SHALL abandon the move; a later chk_done SHALL be ignored.
REQ-033 After reset release, the block SHALL act only on pulses arriving after the first rising clk edge.

Structure
REQ-034 Package tetris_pkg SHALL hold the FSM state encoding, the move-select encoding, the X/Y/ROT widths (4/4/2) and the spawn defaults.
REQ-035 The five pending flags and the priority pick SHALL be one sub-module, move_pending_reg; the FSM and the cur_* registers SHALL stay in piece_commit_ctrl.

Verification
REQ-036 Left commit: pulse btn_left_en at reset state (3,0,0), calculator returns (4,0,0), chk_done=1/chk_collide=0 one cycle after chk_req -> cur=(4,0,0), sel_left high in CHECK/WAIT only, piece_lock stays 0.
REQ-037 Rotate collision: cur=(5,7,3), btn_rotate_en, chk_collide=1 -> cur unchanged (5,7,3), back to IDLE, no piece_lock.
REQ-038 Gravity lock: cur=(2,14,1), gravity_tick, chk_collide=1 -> piece_lock one cycle, cur=(3,0,0) next cycle.
REQ-039 Simultaneous events: btn_right_en and gravity_tick in the same cycle -> R serviced first (sel_right), then GRAV (sel_* all 0); exactly two chk_req pulses.
REQ-040 Lock flushes queue: btn_left_en pulsed during a DN check that collides -> L flag cleared at LOCK, no further chk_req.
REQ-041 Reset mid-WAIT: assert rst_n=0 while waiting, then deliver chk_done -> cur=(3,0,0), no update, busy=0.
